// File: rtl/scie_result_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : scie_result_queue_if
// Description : Handshake bundle between the SCIEPipelined result producer,
//               the result queue and the register-file writeback.
//               slave  - the queue side (accepts results, presents head entry)
//               master - the producer/writeback side
//   io_in_valid / io_in_real / io_in_imag / io_in_tag : incoming result
//   io_out_valid / io_out_ready                       : head-entry handshake
//   io_out_data {imag,real} / io_out_tag              : head entry contents
// Revision    : 1.0 - initial release
// ============================================================================
interface scie_result_queue_if #(
  parameter int TAG_W = 5
);
  logic             io_in_valid;
  logic [15:0]      io_in_real;
  logic [15:0]      io_in_imag;
  logic [TAG_W-1:0] io_in_tag;
  logic             io_out_valid;
  logic             io_out_ready;
  logic [31:0]      io_out_data;
  logic [TAG_W-1:0] io_out_tag;

  modport slave (
    input  io_in_valid, io_in_real, io_in_imag, io_in_tag, io_out_ready,
    output io_out_valid, io_out_data, io_out_tag
  );

  modport master (
    output io_in_valid, io_in_real, io_in_imag, io_in_tag, io_out_ready,
    input  io_out_valid, io_out_data, io_out_tag
  );
endinterface
`default_nettype wire

// File: rtl/scie_result_queue.sv
`default_nettype none
// ============================================================================
// Module      : scie_result_queue
// Description : Circular result queue for complex SCIE results awaiting
//               register writeback. No empty-queue bypass: a pushed entry
//               becomes visible on the cycle after the push. Pushes into a
//               full queue without a same-cycle pop are dropped and flagged.
// Ports       : clock         - sole clock, rising edge
//               reset         - asynchronous, active-low
//               bus (slave)   - result input and head-entry handshake
//               io_clear      - synchronous flush (count, pointers, flags)
//               io_count      - occupied entries (registered)
//               io_full       - io_count == DEPTH (registered)
//               io_overflow   - sticky "a result was dropped"
//               io_drop_count - saturating drop counter
// Options     : define SCIE_RESULT_DROPCNT_EN to build the drop counter;
//               otherwise io_drop_count is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module scie_result_queue #(
  parameter int DEPTH = 4,  // power of two, 2..16
  parameter int TAG_W = 5
) (
  input  logic               clock,
  input  logic               reset,
  scie_result_queue_if.slave bus,
  input  logic               io_clear,
  output logic [4:0]         io_count,
  output logic               io_full,
  output logic               io_overflow,
  output logic [7:0]         io_drop_count
);

  localparam int         PTR_W       = $clog2(DEPTH);
  localparam int         ENTRY_W     = 32 + TAG_W;
  localparam logic [4:0] C_DEPTH_CNT = 5'(DEPTH);

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [4:0]         count_q, count_d;
  logic               full_q, full_d;
  logic               valid_q, valid_d;
  logic               overflow_q, overflow_d;
  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] mem_d [DEPTH];
  logic [ENTRY_W-1:0] head;
  logic               do_push, do_pop, do_drop;

  always_comb begin
    do_pop  = valid_q & bus.io_out_ready;
    // A pop in the same cycle frees the slot, so a full queue still accepts.
    do_push = bus.io_in_valid & (~full_q | do_pop);
    do_drop = bus.io_in_valid & full_q & ~do_pop;

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    mem_d      = mem_q;

    if (io_clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = {bus.io_in_tag, bus.io_in_imag, bus.io_in_real};
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 5'd1;
        2'b01:   count_d = count_q - 5'd1;
        default: count_d = count_q;
      endcase
      if (do_drop) begin
        overflow_d = 1'b1;
      end
    end

    // Status outputs are registered copies derived from the next count.
    full_d  = (count_d == C_DEPTH_CNT);
    valid_d = (count_d != 5'd0);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is not reset; the head is masked while empty so that the
  // data/tag outputs read 0 after reset.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign head             = mem_q[rd_ptr_q];
  assign bus.io_out_valid = valid_q;
  assign bus.io_out_data  = valid_q ? head[31:0] : 32'd0;
  assign bus.io_out_tag   = valid_q ? head[ENTRY_W-1:32] : '0;

  assign io_count    = count_q;
  assign io_full     = full_q;
  assign io_overflow = overflow_q;

`ifdef SCIE_RESULT_DROPCNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (io_clear) begin
      drop_cnt_d = 8'd0;
    end else if (do_drop && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      drop_cnt_q <= 8'd0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign io_drop_count = drop_cnt_q;
`else
  assign io_drop_count = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_scie_result_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_scie_result_queue
// Description : Directed self-checking bench for scie_result_queue
//               (DEPTH=4, TAG_W=5).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scie_result_queue;
  localparam int DEPTH = 4;
  localparam int TAG_W = 5;
`ifdef SCIE_RESULT_DROPCNT_EN
  localparam logic [7:0] EXP_DROP1 = 8'd1;
`else
  localparam logic [7:0] EXP_DROP1 = 8'd0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       io_clear = 1'b0;
  logic [4:0] io_count;
  logic       io_full;
  logic       io_overflow;
  logic [7:0] io_drop_count;
  int         n_cmp = 0;
  int         n_err = 0;

  // Overflow scenario entries and their packed {imag, real} images.
  logic [15:0] ov_re  [4] = '{16'd100, 16'hFFFF, 16'h7FFF, 16'h8000};
  logic [15:0] ov_im  [4] = '{16'hFF38, 16'h0001, 16'h8000, 16'h0000};
  logic [4:0]  ov_tag [4] = '{5'd1, 5'd2, 5'd30, 5'd31};
  logic [31:0] ov_exp [4] = '{32'hFF380064, 32'h0001FFFF, 32'h80007FFF, 32'h00008000};

  // Full-queue push+pop scenario: fill values and the drain order that
  // follows the simultaneous push/pop (last is the (860,-1401) push).
  logic [15:0] fp_re  [4] = '{16'd10, 16'd20, 16'd30, 16'd40};
  logic [15:0] fp_im  [4] = '{16'hFFF6, 16'hFFEC, 16'hFFE2, 16'hFFD8};
  logic [4:0]  fp_tag [4] = '{5'd11, 5'd12, 5'd13, 5'd14};
  logic [31:0] fp_exp [4] = '{32'hFFEC0014, 32'hFFE2001E, 32'hFFD80028, 32'hFA87035C};
  logic [4:0]  fp_etg [4] = '{5'd12, 5'd13, 5'd14, 5'd9};

  scie_result_queue_if #(.TAG_W(TAG_W)) bus ();

  scie_result_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clock        (clock),
    .reset        (reset),
    .bus          (bus.slave),
    .io_clear     (io_clear),
    .io_count     (io_count),
    .io_full      (io_full),
    .io_overflow  (io_overflow),
    .io_drop_count(io_drop_count)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] re, input logic [15:0] im,
                       input logic [4:0] tag);
    bus.io_in_valid = v;
    bus.io_in_real  = re;
    bus.io_in_imag  = im;
    bus.io_in_tag   = tag;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) tick();
    n_cmp++; if (io_count !== 5'd0) begin n_err++; $display("FAIL rst_count: got %0d want 0", io_count); end
    n_cmp++; if (bus.io_out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", bus.io_out_valid); end
    n_cmp++; if (io_full !== 1'b0) begin n_err++; $display("FAIL rst_full: got %b want 0", io_full); end
    n_cmp++; if (io_overflow !== 1'b0) begin n_err++; $display("FAIL rst_overflow: got %b want 0", io_overflow); end
    n_cmp++; if (io_drop_count !== 8'd0) begin n_err++; $display("FAIL rst_drop: got %0d want 0", io_drop_count); end
    n_cmp++; if (bus.io_out_data !== 32'd0) begin n_err++; $display("FAIL rst_data: got %h want 0", bus.io_out_data); end
    n_cmp++; if (bus.io_out_tag !== 5'd0) begin n_err++; $display("FAIL rst_tag: got %0d want 0", bus.io_out_tag); end
    reset = 1'b1;
  endtask

  task automatic test_single_push();
    bus.io_out_ready = 1'b0;
    drive(1'b1, -16'sd774, -16'sd2697, 5'd3);
    #1;
    n_cmp++; if (bus.io_out_valid !== 1'b0) begin n_err++; $display("FAIL sp_no_bypass: got %b want 0", bus.io_out_valid); end
    tick();
    drive(1'b0, 16'd0, 16'd0, 5'd0);
    n_cmp++; if (bus.io_out_valid !== 1'b1) begin n_err++; $display("FAIL sp_valid: got %b want 1", bus.io_out_valid); end
    n_cmp++; if (bus.io_out_data !== 32'hF577FCFA) begin n_err++; $display("FAIL sp_data: got %h want f577fcfa", bus.io_out_data); end
    n_cmp++; if (bus.io_out_tag !== 5'd3) begin n_err++; $display("FAIL sp_tag: got %0d want 3", bus.io_out_tag); end
    n_cmp++; if (io_count !== 5'd1) begin n_err++; $display("FAIL sp_count: got %0d want 1", io_count); end
    tick();
    n_cmp++; if (bus.io_out_data !== 32'hF577FCFA) begin n_err++; $display("FAIL sp_stable: got %h want f577fcfa", bus.io_out_data); end
    bus.io_out_ready = 1'b1;
    tick();
    bus.io_out_ready = 1'b0;
    n_cmp++; if (io_count !== 5'd0) begin n_err++; $display("FAIL sp_drain_count: got %0d want 0", io_count); end
    n_cmp++; if (bus.io_out_valid !== 1'b0) begin n_err++; $display("FAIL sp_drain_valid: got %b want 0", bus.io_out_valid); end
  endtask

  task automatic test_overflow();
    bus.io_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, ov_re[i], ov_im[i], ov_tag[i]);
      tick();
    end
    n_cmp++; if (io_full !== 1'b1) begin n_err++; $display("FAIL ov_full_before: got %b want 1", io_full); end
    drive(1'b1, 16'd163, 16'd2063, 5'd7);
    tick();
    drive(1'b0, 16'd0, 16'd0, 5'd0);
    n_cmp++; if (io_full !== 1'b1) begin n_err++; $display("FAIL ov_full: got %b want 1", io_full); end
    n_cmp++; if (io_count !== 5'd4) begin n_err++; $display("FAIL ov_count: got %0d want 4", io_count); end
    n_cmp++; if (io_overflow !== 1'b1) begin n_err++; $display("FAIL ov_flag: got %b want 1", io_overflow); end
    n_cmp++; if (io_drop_count !== EXP_DROP1) begin n_err++; $display("FAIL ov_drop: got %0d want %0d", io_drop_count, EXP_DROP1); end
    bus.io_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (bus.io_out_valid !== 1'b1) begin n_err++; $display("FAIL ov_drain_valid[%0d]: got %b want 1", i, bus.io_out_valid); end
      n_cmp++; if (bus.io_out_data !== ov_exp[i]) begin n_err++; $display("FAIL ov_drain_data[%0d]: got %h want %h", i, bus.io_out_data, ov_exp[i]); end
      n_cmp++; if (bus.io_out_tag !== ov_tag[i]) begin n_err++; $display("FAIL ov_drain_tag[%0d]: got %0d want %0d", i, bus.io_out_tag, ov_tag[i]); end
      n_cmp++; if (bus.io_out_data === 32'h080F00A3) begin n_err++; $display("FAIL ov_dropped_seen[%0d]: got %h want not 080f00a3", i, bus.io_out_data); end
      tick();
    end
    n_cmp++; if (bus.io_out_valid !== 1'b0) begin n_err++; $display("FAIL ov_empty: got %b want 0", bus.io_out_valid); end
    n_cmp++; if (io_overflow !== 1'b1) begin n_err++; $display("FAIL ov_sticky: got %b want 1", io_overflow); end
    bus.io_out_ready = 1'b0;
  endtask

  task automatic test_full_push_pop();
    bus.io_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, fp_re[i], fp_im[i], fp_tag[i]);
      tick();
    end
    drive(1'b1, 16'd860, -16'sd1401, 5'd9);
    bus.io_out_ready = 1'b1;
    n_cmp++; if (bus.io_out_data !== 32'hFFF6000A) begin n_err++; $display("FAIL fp_head0: got %h want fff6000a", bus.io_out_data); end
    tick();
    drive(1'b0, 16'd0, 16'd0, 5'd0);
    bus.io_out_ready = 1'b0;
    n_cmp++; if (io_count !== 5'd4) begin n_err++; $display("FAIL fp_count: got %0d want 4", io_count); end
    n_cmp++; if (io_full !== 1'b1) begin n_err++; $display("FAIL fp_full: got %b want 1", io_full); end
    n_cmp++; if (io_drop_count !== EXP_DROP1) begin n_err++; $display("FAIL fp_drop: got %0d want %0d", io_drop_count, EXP_DROP1); end
    bus.io_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (bus.io_out_data !== fp_exp[i]) begin n_err++; $display("FAIL fp_drain_data[%0d]: got %h want %h", i, bus.io_out_data, fp_exp[i]); end
      n_cmp++; if (bus.io_out_tag !== fp_etg[i]) begin n_err++; $display("FAIL fp_drain_tag[%0d]: got %0d want %0d", i, bus.io_out_tag, fp_etg[i]); end
      tick();
    end
    n_cmp++; if (io_count !== 5'd0) begin n_err++; $display("FAIL fp_empty: got %0d want 0", io_count); end
    bus.io_out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] re;
    logic [31:0] exp_data;
    bus.io_out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      re       = 16'(i * 16'h0111 + 5);
      exp_data = {~re, re};
      drive(1'b1, re, ~re, 5'(i * 3 + 1));
      tick();
      drive(1'b0, 16'd0, 16'd0, 5'd0);
      n_cmp++; if (bus.io_out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, bus.io_out_valid); end
      n_cmp++; if (bus.io_out_data !== exp_data) begin n_err++; $display("FAIL b2b_data[%0d]: got %h want %h", i, bus.io_out_data, exp_data); end
      n_cmp++; if (bus.io_out_tag !== 5'(i * 3 + 1)) begin n_err++; $display("FAIL b2b_tag[%0d]: got %0d want %0d", i, bus.io_out_tag, i * 3 + 1); end
      n_cmp++; if (io_count !== 5'd1) begin n_err++; $display("FAIL b2b_count1[%0d]: got %0d want 1", i, io_count); end
      tick();
      n_cmp++; if (io_count !== 5'd0) begin n_err++; $display("FAIL b2b_count0[%0d]: got %0d want 0", i, io_count); end
    end
    bus.io_out_ready = 1'b0;
  endtask

  task automatic test_clear();
    bus.io_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'(i + 1), 16'(i + 2), 5'(i));
      tick();
    end
    n_cmp++; if (io_count !== 5'd3) begin n_err++; $display("FAIL clr_pre_count: got %0d want 3", io_count); end
    io_clear = 1'b1;
    drive(1'b1, 16'h5555, 16'hAAAA, 5'd21);
    bus.io_out_ready = 1'b1;
    tick();
    io_clear = 1'b0;
    drive(1'b0, 16'd0, 16'd0, 5'd0);
    bus.io_out_ready = 1'b0;
    n_cmp++; if (io_count !== 5'd0) begin n_err++; $display("FAIL clr_count: got %0d want 0", io_count); end
    n_cmp++; if (bus.io_out_valid !== 1'b0) begin n_err++; $display("FAIL clr_valid: got %b want 0", bus.io_out_valid); end
    n_cmp++; if (io_overflow !== 1'b0) begin n_err++; $display("FAIL clr_overflow: got %b want 0", io_overflow); end
    n_cmp++; if (io_drop_count !== 8'd0) begin n_err++; $display("FAIL clr_drop: got %0d want 0", io_drop_count); end
    tick();
    n_cmp++; if (io_count !== 5'd0) begin n_err++; $display("FAIL clr_push_ignored: got %0d want 0", io_count); end
  endtask

  task automatic test_async_reset();
    bus.io_out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 16'(i + 100), 16'(i + 200), 5'(i + 4));
      tick();
    end
    drive(1'b0, 16'd0, 16'd0, 5'd0);
    n_cmp++; if (io_count !== 5'd2) begin n_err++; $display("FAIL ar_pre_count: got %0d want 2", io_count); end
    #3;
    reset = 1'b0;
    #1;
    n_cmp++; if (io_count !== 5'd0) begin n_err++; $display("FAIL ar_count: got %0d want 0", io_count); end
    n_cmp++; if (bus.io_out_valid !== 1'b0) begin n_err++; $display("FAIL ar_valid: got %b want 0", bus.io_out_valid); end
    #1;
    reset = 1'b1;
    drive(1'b1, 16'h1234, 16'hABCD, 5'd17);
    tick();
    drive(1'b0, 16'd0, 16'd0, 5'd0);
    n_cmp++; if (bus.io_out_valid !== 1'b1) begin n_err++; $display("FAIL ar_post_valid: got %b want 1", bus.io_out_valid); end
    n_cmp++; if (bus.io_out_data !== 32'hABCD1234) begin n_err++; $display("FAIL ar_post_data: got %h want abcd1234", bus.io_out_data); end
    n_cmp++; if (bus.io_out_tag !== 5'd17) begin n_err++; $display("FAIL ar_post_tag: got %0d want 17", bus.io_out_tag); end
    n_cmp++; if (io_count !== 5'd1) begin n_err++; $display("FAIL ar_post_count: got %0d want 1", io_count); end
  endtask

  initial begin
    drive(1'b0, 16'd0, 16'd0, 5'd0);
    bus.io_out_ready = 1'b0;
    test_reset();
    test_single_push();
    test_overflow();
    test_full_push_pop();
    test_back_to_back();
    test_clear();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
